// File: rtl/csd_pkg.sv
// Shared definitions for the CSD encoder: digit codes, FSM encoding and
// the nonzero-digit limit of the downstream position memory.
package csd_pkg;

    localparam logic [7:0] CSD_POS  = 8'h01;
    localparam logic [7:0] CSD_NEG  = 8'hFF;
    localparam logic [7:0] CSD_ZERO = 8'h00;

    // Depth of the downstream nonzero-position memory
    localparam int NZ_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ENC  = 2'b01,
        ST_DONE = 2'b10
    } csd_state_e;

    // True when a digit code carries a nonzero digit
    function automatic logic csd_is_nonzero(input logic [7:0] code);
        return (code != CSD_ZERO);
    endfunction

endpackage

// File: rtl/csd_digit_cell.sv
// One step of the binary-to-CSD recoding: digit at bit i from b[i], b[i+1]
// and the incoming carry, plus the carry into bit i+1.
module csd_digit_cell
    import csd_pkg::*;
(
    input  logic       b_i,
    input  logic       b_i1,
    input  logic       c_in,
    output logic [7:0] digit,
    output logic       c_out
);

    // Digit selection and carry propagation for a single bit position
    always_comb begin
        digit = CSD_ZERO;
        c_out = (b_i & c_in) | ((b_i ^ c_in) & b_i1);
        if (b_i ^ c_in) begin
            if (b_i1) begin
                digit = CSD_NEG;
            end else begin
                digit = CSD_POS;
            end
        end else begin
            digit = CSD_ZERO;
        end
    end

endmodule

// File: rtl/csd_encoder.sv
// Serial binary-to-CSD encoder: writes WIDTH+1 digits, LSB first, into the
// CSD digit memory, one per clock, then pulses done.
// Optional macro CSD_NZCOUNT_EN enables the saturating nonzero-digit counter
// (nz_count) and its overflow flag (nz_ovf); when undefined both are tied low.
// All outputs come straight from registers: the digit for the next write is
// computed one cycle early (from bin_in on the accepting edge, from the
// latched operand afterwards).
module csd_encoder
    import csd_pkg::*;
#(
    parameter int WIDTH  = 15,
    parameter int DIGITS = 16,
    parameter int AW     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             done,
    output logic [2:0]       nz_count,
    output logic             nz_ovf
);

    // Operand zero-extended so that b[WIDTH] and b[WIDTH+1] read as 0
    localparam int EXT_W = 2 ** (AW + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DIGITS - 1);

    csd_state_e       state_r, state_s;
    logic [WIDTH-1:0] operand_r, operand_s;
    logic             carry_r, carry_s;
    logic [AW-1:0]    idx_r, idx_s;
    logic             wr_en_r, wr_en_s;
    logic [7:0]       wr_data_r, wr_data_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic [WIDTH-1:0] src_s;
    logic [EXT_W-1:0] ext_s;
    logic [AW:0]      pos_s;
    logic [AW:0]      pos1_s;
    logic             cin_s;
    logic             b_i_s;
    logic             b_i1_s;
    logic [7:0]       cell_digit_s;
    logic             cell_carry_s;

    // Select the operand bits and carry for the digit that is written next
    always_comb begin
        src_s = operand_r;
        pos_s = '0;
        cin_s = 1'b0;
        if (state_r == ST_IDLE) begin
            src_s = bin_in;
            pos_s = '0;
            cin_s = 1'b0;
        end else begin
            src_s = operand_r;
            pos_s = {1'b0, idx_r} + {{AW{1'b0}}, 1'b1};
            cin_s = carry_r;
        end
        pos1_s = pos_s + {{AW{1'b0}}, 1'b1};
        ext_s  = EXT_W'(src_s);
        b_i_s  = ext_s[pos_s];
        b_i1_s = ext_s[pos1_s];
    end

    csd_digit_cell u_cell (
        .b_i   (b_i_s),
        .b_i1  (b_i1_s),
        .c_in  (cin_s),
        .digit (cell_digit_s),
        .c_out (cell_carry_s)
    );

    // Next-state and next-output decode for IDLE -> ENC -> DONE -> IDLE
    always_comb begin
        state_s   = state_r;
        operand_s = operand_r;
        carry_s   = carry_r;
        idx_s     = idx_r;
        wr_en_s   = 1'b0;
        wr_data_s = CSD_ZERO;
        busy_s    = busy_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_ENC;
                    operand_s = bin_in;
                    idx_s     = '0;
                    carry_s   = cell_carry_s;
                    wr_en_s   = 1'b1;
                    wr_data_s = cell_digit_s;
                    busy_s    = 1'b1;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            ST_ENC: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    idx_s     = idx_r + {{(AW-1){1'b0}}, 1'b1};
                    carry_s   = cell_carry_s;
                    wr_en_s   = 1'b1;
                    wr_data_s = cell_digit_s;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                idx_s   = '0;
                carry_s = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                idx_s   = '0;
                carry_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any conversion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            operand_r <= '0;
            carry_r   <= 1'b0;
            idx_r     <= '0;
            wr_en_r   <= 1'b0;
            wr_data_r <= CSD_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            operand_r <= operand_s;
            carry_r   <= carry_s;
            idx_r     <= idx_s;
            wr_en_r   <= wr_en_s;
            wr_data_r <= wr_data_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = idx_r;
    assign wr_data = wr_data_r;
    assign busy    = busy_r;
    assign done    = done_r;

`ifdef CSD_NZCOUNT_EN
    logic [2:0] nz_count_r;
    logic       nz_ovf_r;
    logic       nz_clr_s;
    logic       nz_inc_s;

    // Counter controls: restart on an accepted start, count each nonzero write
    always_comb begin
        nz_clr_s = (state_r == ST_IDLE) && start;
        nz_inc_s = csd_is_nonzero(wr_data_s);
    end

    // Saturating nonzero-digit counter with sticky overflow beyond NZ_LIMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_count_r <= 3'd0;
            nz_ovf_r   <= 1'b0;
        end else if (nz_clr_s) begin
            nz_count_r <= nz_inc_s ? 3'd1 : 3'd0;
            nz_ovf_r   <= 1'b0;
        end else if (nz_inc_s) begin
            nz_count_r <= (nz_count_r == 3'd7) ? 3'd7 : (nz_count_r + 3'd1);
            nz_ovf_r   <= nz_ovf_r | (nz_count_r >= 3'(NZ_LIMIT));
        end else begin
            nz_count_r <= nz_count_r;
            nz_ovf_r   <= nz_ovf_r;
        end
    end

    assign nz_count = nz_count_r;
    assign nz_ovf   = nz_ovf_r;
`else
    assign nz_count = 3'd0;
    assign nz_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_csd_encoder.sv
// Self-checking bench for csd_encoder: table of known operands, random
// operands against a NAF reference model, and hand-written sequences for
// ignored start, relaunch and mid-conversion reset.
module tb_csd_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [14:0] bin_in;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [2:0]  nz_count;
    logic        nz_ovf;

    csd_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .nz_count (nz_count),
        .nz_ovf   (nz_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [14:0] bin;
        logic [15:0] pos;
        logic [15:0] neg;
        int          nz;
        bit          mid;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   sum    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: non-adjacent form by repeated remainder mod 4
    task automatic naf(input int v, output logic [15:0] pos, output logic [15:0] neg);
        int n;
        n = v;
        pos = 16'h0000;
        neg = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if ((n % 2) != 0) begin
                if ((n % 4) == 3) begin
                    neg[i] = 1'b1;
                    n = n + 1;
                end else begin
                    pos[i] = 1'b1;
                    n = n - 1;
                end
            end
            n = n / 2;
        end
    endtask

    task automatic push_exp(input logic [15:0] pos, input logic [15:0] neg);
        wr_t e;
        for (int a = 0; a < 16; a++) begin
            e.addr = 4'(a);
            e.data = pos[a] ? 8'h01 : (neg[a] ? 8'hFF : 8'h00);
            exp_q.push_back(e);
        end
    endtask

    // Write monitor: every write must match the next expected (addr, data)
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (wr_data == 8'h01) sum += (1 << wr_addr);
            else if (wr_data == 8'hFF) sum -= (1 << wr_addr);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0h", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write actual=%0d:%0h expected=%0d:%0h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic wait_done(input bit mid, output int k);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (mid) start = (k == 5);
        end
        start = 1'b0;
    endtask

    task automatic check_final(input string name, input logic [14:0] bin, input int nz, input int k);
        logic [2:0] ec;
        logic       eo;
`ifdef CSD_NZCOUNT_EN
        ec = (nz > 7) ? 3'd7 : 3'(nz);
        eo = (nz > 4);
`else
        ec = 3'd0;
        eo = 1'b0;
`endif
        chk({name, "_done_latency"}, 32'(k), 32'd17);
        chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        chk({name, "_wren_in_done"}, {31'd0, wr_en}, 32'd0);
        chk({name, "_writes"}, 32'(wr_cnt), 32'd16);
        chk({name, "_sum"}, 32'(sum), {17'd0, bin});
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_nz_count"}, {29'd0, nz_count}, {29'd0, ec});
        chk({name, "_nz_ovf"}, {31'd0, nz_ovf}, {31'd0, eo});
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
        chk({name, "_nz_hold"}, {28'd0, nz_ovf, nz_count}, {28'd0, eo, ec});
    endtask

    task automatic run_op(input string name, input logic [14:0] bin, input logic [15:0] pos,
                          input logic [15:0] neg, input int nz, input bit mid);
        int k;
        @(negedge clk);
        wr_cnt = 0;
        sum    = 0;
        push_exp(pos, neg);
        bin_in = bin;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~bin;
        wait_done(mid, k);
        check_final(name, bin, nz, k);
    endtask

    initial begin
        logic [15:0] p, n;
        logic [14:0] b;
        int k;

        vecs[0] = '{15'h0007, 16'h0008, 16'h0001, 2, 1'b0};
        vecs[1] = '{15'h0003, 16'h0004, 16'h0001, 2, 1'b0};
        vecs[2] = '{15'h7FFF, 16'h8000, 16'h0001, 2, 1'b0};
        vecs[3] = '{15'h5555, 16'h5555, 16'h0000, 8, 1'b0};
        vecs[4] = '{15'h0000, 16'h0000, 16'h0000, 0, 1'b1};
        vecs[5] = '{15'h000B, 16'h0010, 16'h0005, 3, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 15'h0000;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {16'd0, wr_en, wr_addr, wr_data, busy, done, nz_count, nz_ovf}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].bin, vecs[i].pos, vecs[i].neg,
                   vecs[i].nz, vecs[i].mid);
        end

        for (int i = 0; i < 6; i++) begin
            b = 15'($urandom_range(0, 32767));
            naf(int'(b), p, n);
            run_op($sformatf("rnd%0d", i), b, p, n, $countones(p | n), 1'b0);
        end

        // Relaunch: start held high through ENC and DONE
        @(negedge clk);
        wr_cnt = 0;
        sum    = 0;
        push_exp(16'h0008, 16'h0001);
        bin_in = 15'h0007;
        start  = 1'b1;
        @(negedge clk);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("relaunch_first_latency", 32'(k), 32'd17);
        chk("relaunch_first_writes", 32'(wr_cnt), 32'd16);
        push_exp(16'h0004, 16'h0001);
        bin_in = 15'h0003;
        @(negedge clk);
        chk("relaunch_idle_gap", {30'd0, wr_en, busy}, 32'd0);
        wr_cnt = 0;
        sum    = 0;
        @(negedge clk);
        start = 1'b0;
        chk("relaunch_first_write", {19'd0, wr_en, wr_addr, wr_data}, {19'd0, 1'b1, 4'd0, 8'hFF});
        wait_done(1'b0, k);
        check_final("relaunch_second", 15'h0003, 2, k);

        // Reset while address 5 is being written
        @(negedge clk);
        wr_cnt = 0;
        push_exp(16'h5555, 16'h0000);
        bin_in = 15'h5555;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_addr", {27'd0, wr_en, wr_addr}, {27'd0, 1'b1, 4'd5});
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("abort_outputs", {16'd0, wr_en, wr_addr, wr_data, busy, done, nz_count, nz_ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wr_cnt = 0;
        repeat (4) @(negedge clk);
        chk("abort_no_writes", 32'(wr_cnt), 32'd0);
        run_op("after_reset", 15'h0007, 16'h0008, 16'h0001, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
